// File: rtl/prod_accumulator_pkg.sv
// Shared types and default sizing for the product accumulator.
package prod_accumulator_pkg;

  typedef enum logic {
    ACC  = 1'b0,
    HOLD = 1'b1
  } state_t;

  localparam int N_TERMS_DEF = 4;
  localparam int ACC_W_DEF   = 8;

endpackage

// File: rtl/acc_adder.sv
// Unsigned W-bit adder with carry-out, shared by accumulate and overflow paths.
module acc_adder #(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] sum,
  output logic         carry
);

  assign {carry, sum} = {1'b0, a} + {1'b0, b};

endmodule

// File: rtl/prod_accumulator.sv
// Sums N_TERMS multiplier products into one result and holds it until taken.
// state | meaning
// ACC   | collecting products, in_ready high
// HOLD  | presenting out_sum/out_ovf, out_valid high
module prod_accumulator
  import prod_accumulator_pkg::*;
#(
  parameter int N_TERMS = N_TERMS_DEF,
  parameter int ACC_W   = ACC_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [5:0]       in_prod,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_sum,
  output logic             out_ovf
);

  localparam int CNT_W = $clog2(N_TERMS + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(N_TERMS - 1);

  state_t           state, state_nxt;
  logic [ACC_W-1:0] acc, acc_nxt, add_sum, prod_ext;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             ovf, ovf_nxt, add_carry, accept;

  assign prod_ext = ACC_W'(in_prod);

  acc_adder #(.W(ACC_W)) u_adder (
    .a     (acc),
    .b     (prod_ext),
    .sum   (add_sum),
    .carry (add_carry)
  );

  assign in_ready  = (state == ACC);
  assign out_valid = (state == HOLD);
  assign accept    = in_valid & in_ready;
  assign out_sum   = acc;
  assign out_ovf   = ovf;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ACC;
      acc   <= '0;
      cnt   <= '0;
      ovf   <= 1'b0;
    end else begin
      state <= state_nxt;
      acc   <= acc_nxt;
      cnt   <= cnt_nxt;
      ovf   <= ovf_nxt;
    end
  end

  // flush outranks both accept and the output handshake
  always_comb begin
    state_nxt = state;
    acc_nxt   = acc;
    cnt_nxt   = cnt;
    ovf_nxt   = ovf;
    if (flush) begin
      state_nxt = ACC;
      acc_nxt   = '0;
      cnt_nxt   = '0;
      ovf_nxt   = 1'b0;
    end else begin
      case (state)
        ACC: begin
          if (accept) begin
            acc_nxt = add_sum;
            ovf_nxt = ovf | add_carry;
            if (cnt == LAST) begin
              state_nxt = HOLD;
              cnt_nxt   = '0;
            end else begin
              cnt_nxt = cnt + CNT_W'(1);
            end
          end
        end
        HOLD: begin
          if (out_ready) begin
            state_nxt = ACC;
            acc_nxt   = '0;
            cnt_nxt   = '0;
            ovf_nxt   = 1'b0;
          end
        end
        default: state_nxt = ACC;
      endcase
    end
  end

endmodule

// File: tb/tb_prod_accumulator.sv
// Drives a 4-term and an 8-term accumulator from shared inputs against a frame-sum model.
module tb_prod_accumulator;

  logic       clk = 1'b0;
  logic       rst, in_valid, flush, out_ready;
  logic [5:0] in_prod;
  logic       a_in_ready, a_out_valid, a_out_ovf;
  logic [7:0] a_out_sum;
  logic       b_in_ready, b_out_valid, b_out_ovf;
  logic [7:0] b_out_sum;

  int n_checks = 0;
  int n_errors = 0;

  bit m_hold[2];
  int m_total[2];
  int m_count[2];

  always #5 clk = ~clk;

  prod_accumulator dut_a (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(a_in_ready),
    .in_prod(in_prod), .flush(flush), .out_valid(a_out_valid),
    .out_ready(out_ready), .out_sum(a_out_sum), .out_ovf(a_out_ovf)
  );

  prod_accumulator #(.N_TERMS(8), .ACC_W(8)) dut_b (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(b_in_ready),
    .in_prod(in_prod), .flush(flush), .out_valid(b_out_valid),
    .out_ready(out_ready), .out_sum(b_out_sum), .out_ovf(b_out_ovf)
  );

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // A frame is just a running integer total and a count of accepted products.
  task automatic model_update(input int d, input int n);
    if (rst || flush) begin
      m_hold[d]  = 1'b0;
      m_total[d] = 0;
      m_count[d] = 0;
    end else if (!m_hold[d]) begin
      if (in_valid) begin
        m_total[d] += int'(in_prod);
        m_count[d]++;
        if (m_count[d] == n) begin
          m_hold[d]  = 1'b1;
          m_count[d] = 0;
        end
      end
    end else if (out_ready) begin
      m_hold[d]  = 1'b0;
      m_total[d] = 0;
    end
  endtask

  task automatic compare(input int d);
    string p;
    logic r, v, o;
    logic [7:0] s;
    p = (d == 0) ? "a" : "b";
    r = (d == 0) ? a_in_ready  : b_in_ready;
    v = (d == 0) ? a_out_valid : b_out_valid;
    o = (d == 0) ? a_out_ovf   : b_out_ovf;
    s = (d == 0) ? a_out_sum   : b_out_sum;
    check_eq({p, ".in_ready"}, int'(r), int'(!m_hold[d]));
    check_eq({p, ".out_valid"}, int'(v), int'(m_hold[d]));
    if (m_hold[d]) begin
      check_eq({p, ".out_sum"}, int'(s), m_total[d] % 256);
      check_eq({p, ".out_ovf"}, int'(o), int'(m_total[d] > 255));
    end
  endtask

  task automatic step();
    model_update(0, 4);
    model_update(1, 8);
    @(posedge clk);
    #1;
    compare(0);
    compare(1);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1; in_prod = '0;
    step();
    step();
    rst = 1'b0;
    check_eq("reset a.out_sum", int'(a_out_sum), 0);
    check_eq("reset a.out_ovf", int'(a_out_ovf), 0);
    check_eq("reset b.out_sum", int'(b_out_sum), 0);
    check_eq("reset a.in_ready", int'(a_in_ready), 1);

    // basic frame, then 5 cycles of backpressure while b completes its 8-term overflow frame
    in_valid = 1'b1; in_prod = 6'd49; out_ready = 1'b0;
    for (int i = 0; i < 4; i++) step();
    check_eq("basic a.out_sum", int'(a_out_sum), 196);
    check_eq("basic a.out_ovf", int'(a_out_ovf), 0);
    for (int i = 0; i < 4; i++) step();
    check_eq("ovf b.out_sum", int'(b_out_sum), 136);
    check_eq("ovf b.out_ovf", int'(b_out_ovf), 1);
    step();
    check_eq("bp a.out_sum", int'(a_out_sum), 196);
    check_eq("bp a.in_ready", int'(a_in_ready), 0);

    in_prod = 6'd1; out_ready = 1'b1;
    step();
    for (int i = 0; i < 8; i++) step();
    check_eq("ones b.out_valid", int'(b_out_valid), 1);
    check_eq("ones b.out_sum", int'(b_out_sum), 8);
    check_eq("ones b.out_ovf", int'(b_out_ovf), 0);

    // flush drops the product presented with it
    in_valid = 1'b0; flush = 1'b1;
    step();
    flush = 1'b0; in_valid = 1'b1;
    in_prod = 6'd30; step();
    in_prod = 6'd20; step();
    in_prod = 6'd63; flush = 1'b1; step();
    flush = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      in_prod = 6'(i);
      step();
    end
    check_eq("flush a.out_sum", int'(a_out_sum), 10);

    // reset mid-frame
    in_valid = 1'b0; flush = 1'b1; step();
    flush = 1'b0; in_valid = 1'b1;
    in_prod = 6'd7; step();
    in_prod = 6'd9; step();
    rst = 1'b1; in_prod = 6'd11; step();
    rst = 1'b0;
    check_eq("rst a.out_sum", int'(a_out_sum), 0);
    check_eq("rst a.out_ovf", int'(a_out_ovf), 0);
    check_eq("rst a.out_valid", int'(a_out_valid), 0);
    check_eq("rst b.in_ready", int'(b_in_ready), 1);
    in_prod = 6'd5;
    for (int i = 0; i < 4; i++) step();
    check_eq("rst a.next_sum", int'(a_out_sum), 20);

    // back-to-back with out_ready tied high
    out_ready = 1'b1; in_valid = 1'b1;
    for (int i = 0; i < 60; i++) begin
      in_prod = 6'($urandom_range(0, 63));
      step();
    end

    // random traffic with occasional flush and reset
    for (int i = 0; i < 400; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      in_prod   = 6'($urandom_range(0, 63));
      flush     = ($urandom_range(0, 24) == 0);
      rst       = ($urandom_range(0, 59) == 0);
      step();
    end
    rst = 1'b0; flush = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
